// File: rtl/mc_ctrl.sv
// Multi-cycle controller for a five-state IF/ID/EX/MEM/WB datapath.
// Define MC_CTRL_PERF_EN to build the retired-instruction counter; otherwise instret reads 0.
module mc_ctrl #(
  parameter int                OP_W    = 6,
  parameter int                FUNC_W  = 11,
  parameter int                CNT_W   = 32,
  parameter logic [FUNC_W-1:0] ALU_ADD = 11'h020,
  parameter logic [FUNC_W-1:0] ALU_SUB = 11'h022
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic              equal,
  input  logic              imem_rdy,
  input  logic              dmem_rdy,
  output logic              imem_req,
  output logic              ir_en,
  output logic              pc_en,
  output logic              pc_sel,
  output logic              a_sel,
  output logic              b_sel,
  output logic [FUNC_W-1:0] alu_op,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              rf_we,
  output logic              wb_sel,
  output logic              mem2reg,
  output logic [2:0]        state,
  output logic              illegal,
  output logic [CNT_W-1:0]  instret
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_R   = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OP_W-1:0] OP_J   = 6'b000010;

  state_t          st;
  logic            run;
  logic [OP_W-1:0] op_q;
  logic            eq_q;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

  assign state = st;

  // run holds fetch off for the cycle in which rst is still being sampled high
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_IF;
      run     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      run <= 1'b1;
      case (st)
        S_IF: if (run && imem_rdy) st <= S_ID;
        S_ID: begin
          if (!is_legal(opcode)) begin
            illegal <= 1'b1;
            st      <= S_IF;
          end else begin
            st <= S_EX;
          end
        end
        S_EX: begin
          case (op_q)
            OP_R:                 st <= S_WB;
            OP_LW, OP_SW, OP_BEQ: st <= S_MEM;
            default:              st <= S_IF;
          endcase
        end
        S_MEM: begin
          if (op_q == OP_BEQ)  st <= S_IF;
          else if (dmem_rdy)   st <= (op_q == OP_LW) ? S_WB : S_IF;
        end
        default: st <= S_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (st == S_ID) op_q <= opcode;
    if (st == S_EX) eq_q <= equal;
  end

  always_comb begin
    imem_req = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    alu_op   = '0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    mem2reg  = 1'b0;
    case (st)
      S_IF: begin
        if (run) begin
          imem_req = 1'b1;
          ir_en    = imem_rdy;
          pc_en    = imem_rdy;
        end
      end
      S_EX: begin
        case (op_q)
          OP_R: begin
            a_sel  = 1'b1;
            alu_op = func;
          end
          OP_LW, OP_SW: begin
            a_sel  = 1'b1;
            b_sel  = 1'b1;
            alu_op = ALU_ADD;
          end
          OP_BEQ: begin
            a_sel  = 1'b1;
            alu_op = ALU_SUB;
          end
          OP_J: begin
            b_sel  = 1'b1;
            alu_op = ALU_ADD;
            pc_en  = 1'b1;
            pc_sel = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // BEQ reuses MEM to form the target; the PC load is gated by the EX compare
        if (op_q == OP_BEQ) begin
          b_sel  = 1'b1;
          alu_op = ALU_ADD;
          pc_en  = eq_q;
          pc_sel = eq_q;
        end else begin
          dmem_req = 1'b1;
          dmem_we  = (op_q == OP_SW);
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        if (op_q == OP_LW) wb_sel  = 1'b1;
        else               mem2reg = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  logic            done;
  logic [CNT_W-1:0] cnt;

  assign done = (st == S_WB) ||
                ((st == S_EX) && (op_q == OP_J)) ||
                ((st == S_MEM) && ((op_q == OP_BEQ) || ((op_q == OP_SW) && dmem_rdy)));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (done) cnt <= cnt + 1'b1;
  end

  assign instret = cnt;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; builds with or without MC_CTRL_PERF_EN.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // field order: state | imem_req ir_en pc_en pc_sel | a_sel b_sel | dmem_req dmem_we | rf_we wb_sel mem2reg
  localparam logic [13:0] E_FETCH = 14'b000_1110_00_00_000;
  localparam logic [13:0] E_WAIT  = 14'b000_1000_00_00_000;
  localparam logic [13:0] E_ID    = 14'b001_0000_00_00_000;
  localparam logic [13:0] E_EXR   = 14'b010_0000_10_00_000;
  localparam logic [13:0] E_EXM   = 14'b010_0000_11_00_000;
  localparam logic [13:0] E_EXJ   = 14'b010_0011_01_00_000;
  localparam logic [13:0] E_MLW   = 14'b011_0000_00_10_000;
  localparam logic [13:0] E_MSW   = 14'b011_0000_00_11_000;
  localparam logic [13:0] E_MBT   = 14'b011_0011_01_00_000;
  localparam logic [13:0] E_MBN   = 14'b011_0000_01_00_000;
  localparam logic [13:0] E_WBR   = 14'b100_0000_00_00_101;
  localparam logic [13:0] E_WBL   = 14'b100_0000_00_00_110;

  logic        clk = 1'b0;
  logic        rst, equal, imem_rdy, dmem_rdy;
  logic [5:0]  opcode;
  logic [10:0] func;
  logic        imem_req, ir_en, pc_en, pc_sel, a_sel, b_sel;
  logic [10:0] alu_op;
  logic        dmem_req, dmem_we, rf_we, wb_sel, mem2reg, illegal;
  logic [2:0]  state;
  logic [3:0]  instret;
  logic [13:0] obs;
  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  logic [3:0]  exp_ir;

  mc_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .equal(equal),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .imem_req(imem_req), .ir_en(ir_en),
    .pc_en(pc_en), .pc_sel(pc_sel), .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .mem2reg(mem2reg), .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs = {state, imem_req, ir_en, pc_en, pc_sel, a_sel, b_sel,
                dmem_req, dmem_we, rf_we, wb_sel, mem2reg};

  task automatic step(input logic ir, input logic dr, input logic eq, input logic [5:0] op);
    imem_rdy = ir;
    dmem_rdy = dr;
    equal    = eq;
    opcode   = op;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, OP_R);
    tick;
    tick;
    n_chk++;
    if ({obs, alu_op, illegal, instret} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_state obs=%b alu=%h ill=%b ir=%0d required all zero", obs, alu_op, illegal, instret);
    end
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, OP_R);
    n_chk++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_same_cycle imem_req=%b required 0", imem_req);
    end
    tick;
    n_chk++;
    if (obs !== E_WAIT) begin
      n_fail++;
      $display("FAIL reset_first_fetch obs=%b required %b", obs, E_WAIT);
    end
  endtask

  task automatic test_rtype;
    logic [13:0] e [5];
    logic [10:0] a [5];
    logic [10:0] fv;
    for (int k = 0; k < 2; k++) begin
      fv   = (k == 0) ? 11'h020 : 11'h7A5;
      func = fv;
      e = '{E_FETCH, E_ID, E_EXR, E_WBR, E_WAIT};
      a = '{11'h0, 11'h0, fv, 11'h0, 11'h0};
      for (int i = 0; i < 5; i++) begin
        step(i < 4, 1'b1, 1'b0, (i <= 1) ? OP_R : OP_BAD);
        n_chk++;
        if ({obs, alu_op} !== {e[i], a[i]}) begin
          n_fail++;
          $display("FAIL rtype k%0d cyc%0d obs=%b alu=%h required %b alu=%h", k, i, obs, alu_op, e[i], a[i]);
        end
        tick;
      end
      exp_cnt++;
    end
    exp_ir = PERF ? 4'(exp_cnt) : 4'd0;
    n_chk++;
    if ({illegal, instret} !== {1'b0, exp_ir}) begin
      n_fail++;
      $display("FAIL rtype_count ill=%b ir=%0d required ill=0 ir=%0d", illegal, instret, exp_ir);
    end
  endtask

  task automatic test_lw_wait;
    logic [13:0] e [9];
    logic [10:0] a [9];
    logic        d [9];
    e = '{E_FETCH, E_ID, E_EXM, E_MLW, E_MLW, E_MLW, E_MLW, E_WBL, E_WAIT};
    a = '{11'h0, 11'h0, 11'h020, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0};
    d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      step(i < 8, d[i], 1'b0, (i <= 1) ? OP_LW : OP_BAD);
      n_chk++;
      if ({obs, alu_op} !== {e[i], a[i]}) begin
        n_fail++;
        $display("FAIL lw_wait cyc%0d obs=%b alu=%h required %b alu=%h", i, obs, alu_op, e[i], a[i]);
      end
      tick;
    end
    exp_cnt++;
    exp_ir = PERF ? 4'(exp_cnt) : 4'd0;
    n_chk++;
    if (instret !== exp_ir) begin
      n_fail++;
      $display("FAIL lw_count ir=%0d required %0d", instret, exp_ir);
    end
  endtask

  task automatic test_sw_fetch_wait;
    logic [13:0] e [6];
    logic [10:0] a [6];
    logic        f [6];
    e = '{E_WAIT, E_FETCH, E_ID, E_EXM, E_MSW, E_WAIT};
    a = '{11'h0, 11'h0, 11'h0, 11'h020, 11'h0, 11'h0};
    f = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(f[i], 1'b1, 1'b0, (i <= 2) ? OP_SW : OP_BAD);
      n_chk++;
      if ({obs, alu_op} !== {e[i], a[i]}) begin
        n_fail++;
        $display("FAIL sw cyc%0d obs=%b alu=%h required %b alu=%h", i, obs, alu_op, e[i], a[i]);
      end
      tick;
    end
    exp_cnt++;
    exp_ir = PERF ? 4'(exp_cnt) : 4'd0;
    n_chk++;
    if (instret !== exp_ir) begin
      n_fail++;
      $display("FAIL sw_count ir=%0d required %0d", instret, exp_ir);
    end
  endtask

  task automatic test_beq;
    logic [13:0] e [5];
    logic [10:0] a [5];
    logic        eqv;
    for (int k = 0; k < 2; k++) begin
      eqv = (k == 0);
      e = '{E_FETCH, E_ID, E_EXR, eqv ? E_MBT : E_MBN, E_WAIT};
      a = '{11'h0, 11'h0, 11'h022, 11'h020, 11'h0};
      for (int i = 0; i < 5; i++) begin
        step(i < 4, 1'b0, (i == 2) ? eqv : ~eqv, (i <= 1) ? OP_BEQ : OP_BAD);
        n_chk++;
        if ({obs, alu_op} !== {e[i], a[i]}) begin
          n_fail++;
          $display("FAIL beq eq%0b cyc%0d obs=%b alu=%h required %b alu=%h", eqv, i, obs, alu_op, e[i], a[i]);
        end
        tick;
      end
      exp_cnt++;
    end
    exp_ir = PERF ? 4'(exp_cnt) : 4'd0;
    n_chk++;
    if (instret !== exp_ir) begin
      n_fail++;
      $display("FAIL beq_count ir=%0d required %0d", instret, exp_ir);
    end
  endtask

  task automatic test_illegal;
    logic [14:0] e [4];
    e = '{{E_FETCH, 1'b0}, {E_ID, 1'b0}, {E_WAIT, 1'b1}, {E_WAIT, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      step(i < 2, 1'b1, 1'b0, OP_BAD);
      n_chk++;
      if ({obs, illegal} !== e[i]) begin
        n_fail++;
        $display("FAIL illegal cyc%0d obs=%b ill=%b required %b", i, obs, illegal, e[i]);
      end
      tick;
    end
    exp_ir = PERF ? 4'(exp_cnt) : 4'd0;
    n_chk++;
    if ({alu_op, instret} !== {11'h0, exp_ir}) begin
      n_fail++;
      $display("FAIL illegal_count alu=%h ir=%0d required alu=0 ir=%0d", alu_op, instret, exp_ir);
    end
  endtask

  task automatic test_reset_in_mem;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, (i <= 1) ? OP_LW : OP_BAD);
      tick;
    end
    n_chk++;
    if (obs !== E_MLW) begin
      n_fail++;
      $display("FAIL mem_wait_before_rst obs=%b required %b", obs, E_MLW);
    end
    rst = 1'b1;
    tick;
    n_chk++;
    if ({obs, alu_op, illegal, instret} !== 30'd0) begin
      n_fail++;
      $display("FAIL rst_in_mem obs=%b alu=%h ill=%b ir=%0d required all zero", obs, alu_op, illegal, instret);
    end
    rst = 1'b0;
    exp_cnt = 0;
    step(1'b0, 1'b1, 1'b0, OP_BAD);
    tick;
    n_chk++;
    if (obs !== E_WAIT) begin
      n_fail++;
      $display("FAIL rst_in_mem_refetch obs=%b required %b", obs, E_WAIT);
    end
  endtask

  task automatic test_back_to_back_j;
    for (int k = 0; k < 17; k++) begin
      step(1'b1, 1'b1, 1'b0, OP_J);
      tick;
      tick;
      step(1'b0, 1'b1, 1'b0, OP_BAD);
      n_chk++;
      if ({obs, alu_op} !== {E_EXJ, 11'h020}) begin
        n_fail++;
        $display("FAIL j_ex k%0d obs=%b alu=%h required %b alu=020", k, obs, alu_op, E_EXJ);
      end
      tick;
      n_chk++;
      if (obs !== E_WAIT) begin
        n_fail++;
        $display("FAIL j_return k%0d obs=%b required %b", k, obs, E_WAIT);
      end
      exp_cnt++;
    end
    exp_ir = PERF ? 4'(exp_cnt) : 4'd0;
    n_chk++;
    if (instret !== exp_ir) begin
      n_fail++;
      $display("FAIL j_wrap_count ir=%0d required %0d", instret, exp_ir);
    end
  endtask

  initial begin
    rst = 1'b1;
    func = 11'h0;
    test_reset;
    test_rtype;
    test_lw_wait;
    test_sw_fetch_wait;
    test_beq;
    test_illegal;
    test_reset_in_mem;
    test_back_to_back_j;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter OP_W, default 6, opcode width.
REQ-002 Parameter FUNC_W, default 11, function/alu_op width.
REQ-003 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 Parameter ALU_ADD, default 11'h020, alu_op code for address/target add.
REQ-005 Parameter ALU_SUB, default 11'h022, alu_op code for branch compare.
REQ-006 Port clk  in  1  single clock; every flop updates on rising edge.
REQ-007 Port rst  in  1  synchronous, active-high reset.
REQ-008 Port opcode  in  OP_W  IR[31:26], valid from ID onward.
REQ-009 Port func  in  FUNC_W  IR[10:0].
REQ-010 Port equal  in  1  ALU compare result, sampled in EX.
REQ-011 Port imem_rdy  in  1  instruction memory data valid.
REQ-012 Port dmem_rdy  in  1  data memory access complete.
REQ-013 Port imem_req  out  1  instruction fetch request.
REQ-014 Port ir_en  out  1  IR and NPC load strobe.
REQ-015 Port pc_en  out  1  PC load strobe.
REQ-016 Port pc_sel  out  1  1 = PC from ALU output, 0 = PC+4.
REQ-017 Port a_sel  out  1  ALU A: 1 = register A, 0 = NPC.
REQ-018 Port b_sel  out  1  ALU B: 1 = immediate, 0 = register B.
REQ-019 Port alu_op  out  FUNC_W  ALU operation code.
REQ-020 Port dmem_req / dmem_we  out  1 each  data access request / write qualifier.
REQ-021 Port rf_we / wb_sel / mem2reg  out  1 each  reg write; dest 1=rt 0=rd; data 1=ALU 0=LMD.
REQ-022 Port state / illegal / instret  out  3 / 1 / CNT_W  FSM state; sticky bad-opcode flag; retired count.

Function
REQ-023 States IF=0, ID=1, EX=2, MEM=3, WB=4; all other codes return to IF next cycle.
REQ-024 Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010; any other is illegal.
REQ-025 IF: imem_req=1; stay while imem_rdy=0; on imem_rdy=1 pulse ir_en=1 and pc_en=1 (pc_sel=0), go ID.
REQ-026 ID: all strobes 0; illegal opcode sets illegal=1 and returns to IF; else go EX.
REQ-027 EX, R: a_sel=1, b_sel=0, alu_op=func, go WB.
REQ-028 EX, LW/SW: a_sel=1, b_sel=1, alu_op=ALU_ADD, go MEM.
REQ-029 EX, BEQ: a_sel=1, b_sel=0, alu_op=ALU_SUB; record equal; go MEM as branch-target phase.
REQ-030 EX, J: a_sel=0, b_sel=1, alu_op=ALU_ADD, pc_en=1, pc_sel=1, go IF.
REQ-031 MEM, BEQ: a_sel=0, b_sel=1, alu_op=ALU_ADD; pc_en=pc_sel=recorded equal; go IF; no dmem_req.
REQ-032 MEM, LW/SW: dmem_req=1, dmem_we=(SW); hold until dmem_rdy=1; then LW to WB, SW to IF.
REQ-033 WB: rf_we=1 one cycle; R: wb_sel=0, mem2reg=1; LW: wb_sel=1, mem2reg=0; go IF.
REQ-034 Zero-wait latency: R 4, LW 5, SW 4, BEQ 4, J 3, illegal 2 cycles; +1 per cycle of rdy low.
REQ-035 Every strobe is a single-cycle pulse; outputs are Moore-decoded from state plus latched opcode, except IF/MEM handshake qualified by rdy.
REQ-036 Opcode latched at ID entry; later opcode changes ignored until next ID.

Reset
REQ-037 rst=1 forces state=IF, all strobes/selects 0, alu_op=0, illegal=0, instret=0; it overrides any wait, including mid-MEM (dmem_req drops the next cycle).
REQ-038 imem_req first asserts in the cycle after rst deasserts.

Configuration
REQ-039 Macro MC_CTRL_PERF_EN defined: instret increments on every completed legal instruction (WB exit, SW/BEQ MEM exit, J EX exit), wrapping at 2^CNT_W.
REQ-040 MC_CTRL_PERF_EN undefined: no counter flops; instret tied to 0; all other behaviour identical.

Verification
REQ-041 R-type, func=11'h020, rdy always 1 -> states 0,1,2,4,0; rf_we=1 only in cycle 4; alu_op=11'h020 in EX.
REQ-042 LW, dmem_rdy low for 3 cycles -> MEM lasts 4 cycles with dmem_req=1, dmem_we=0; rf_we pulse with wb_sel=1, mem2reg=0; total 8 cycles.
REQ-043 BEQ with equal=1 then equal=0 -> pc_en=pc_sel=1 in MEM only for first; both 4 cycles.
REQ-044 Opcode 111111 -> illegal=1 after ID, back to IF, no strobes; illegal stays 1 until rst.
REQ-045 rst asserted during LW MEM wait -> next cycle state=0, dmem_req=0, instret=0.
REQ-046 PERF build, CNT_W=4, 17 J instructions -> instret=1; non-PERF build -> instret=0.
